// File: rtl/ctrl_decode_pipe_if.sv
// Instruction-in / control-beat-out bundle between fetch and the decode pipe.
// master drives instructions and takes beats; slave is the decoder.
interface ctrl_decode_pipe_if #(
  parameter int IW   = 9,
  parameter int IMMW = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [IW-1:0]   instruction;
  logic            out_valid;
  logic            out_ready;
  logic            branchFlag;
  logic            memToRegFlag;
  logic            memWriteFlag;
  logic            regWriteFlag;
  logic            immtoRegFlag;
  logic [3:0]      ALUOp;
  logic [IMMW-1:0] imm;
  logic            illegal;
  logic            put_overflow;

  modport master (
    output in_valid, instruction, out_ready,
    input  in_ready, out_valid, branchFlag, memToRegFlag, memWriteFlag,
           regWriteFlag, immtoRegFlag, ALUOp, imm, illegal, put_overflow
  );

  modport slave (
    input  in_valid, instruction, out_ready,
    output in_ready, out_valid, branchFlag, memToRegFlag, memWriteFlag,
           regWriteFlag, immtoRegFlag, ALUOp, imm, illegal, put_overflow
  );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// Control decoder: put words build a wide immediate, run words emit a registered beat.
// Beat appears 1 cycle after a run word; in_ready drops while a beat is stalled.
module ctrl_decode_pipe #(
  parameter int IW   = 9,
  parameter int OPW  = 4,
  parameter int IMMW = 16
) (
  input logic                clk,
  input logic                rst_n,
  ctrl_decode_pipe_if.slave  bus
);
  localparam int VW   = IW - 1;
  localparam int PUTS = IMMW / VW;
  localparam int CW   = $clog2(PUTS + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IMMW-1:0] acc_q, acc_d;
  logic            out_valid_q, out_valid_d;
  logic            branch_q, branch_d;
  logic            mem_to_reg_q, mem_to_reg_d;
  logic            mem_write_q, mem_write_d;
  logic            reg_write_q, reg_write_d;
  logic            imm_to_reg_q, imm_to_reg_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [IMMW-1:0] imm_q, imm_d;
  logic            illegal_q, illegal_d;
  logic            put_overflow_q, put_overflow_d;

  logic               in_ready;
  logic               fire;
  logic [OPW-1:0]     opcode;
  logic [IMMW+VW-1:0] shifted;

  assign in_ready = rst_n & (~out_valid_q | bus.out_ready);
  assign fire     = bus.in_valid & in_ready;
  assign opcode   = bus.instruction[OPW:1];
  // Oldest chunk falls off the top once the immediate is full.
  assign shifted  = {acc_q, bus.instruction[IW-1:1]};

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    out_valid_d    = out_valid_q;
    branch_d       = branch_q;
    mem_to_reg_d   = mem_to_reg_q;
    mem_write_d    = mem_write_q;
    reg_write_d    = reg_write_q;
    imm_to_reg_d   = imm_to_reg_q;
    alu_op_d       = alu_op_q;
    imm_d          = imm_q;
    illegal_d      = illegal_q;
    put_overflow_d = 1'b0;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    if (fire && bus.instruction[0]) begin
      acc_d = shifted[IMMW-1:0];
      if (state_q == FULL) begin
        put_overflow_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      state_d = (cnt_d == CW'(PUTS)) ? FULL : COLLECT;
    end else if (fire) begin
      state_d      = IDLE;
      cnt_d        = '0;
      acc_d        = '0;
      imm_d        = acc_q;
      out_valid_d  = 1'b1;
      branch_d     = 1'b0;
      mem_to_reg_d = 1'b0;
      mem_write_d  = 1'b0;
      reg_write_d  = 1'b1;
      imm_to_reg_d = 1'b0;
      alu_op_d     = 4'b1111;
      illegal_d    = 1'b0;
      case (opcode)
        OPW'(0):  imm_to_reg_d = 1'b1;
        OPW'(1):  mem_to_reg_d = 1'b1;
        OPW'(2):  begin mem_write_d = 1'b1; reg_write_d = 1'b0; end
        OPW'(3):  alu_op_d = 4'b0101;
        OPW'(4):  alu_op_d = 4'b0110;
        OPW'(5):  alu_op_d = 4'b0001;
        OPW'(6):  alu_op_d = 4'b0010;
        OPW'(7):  alu_op_d = 4'b0000;
        OPW'(8):  begin branch_d = 1'b1; reg_write_d = 1'b0; end
        OPW'(9):  begin alu_op_d = 4'b1001; reg_write_d = 1'b0; end
        OPW'(10): begin alu_op_d = 4'b0111; reg_write_d = 1'b0; end
        OPW'(11): begin alu_op_d = 4'b1000; reg_write_d = 1'b0; end
        OPW'(12): alu_op_d = 4'b0011;
        OPW'(13): alu_op_d = 4'b0100;
        default:  begin illegal_d = 1'b1; reg_write_d = 1'b0; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      acc_q          <= '0;
      out_valid_q    <= 1'b0;
      branch_q       <= 1'b0;
      mem_to_reg_q   <= 1'b0;
      mem_write_q    <= 1'b0;
      reg_write_q    <= 1'b0;
      imm_to_reg_q   <= 1'b0;
      alu_op_q       <= 4'b1111;
      imm_q          <= '0;
      illegal_q      <= 1'b0;
      put_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      out_valid_q    <= out_valid_d;
      branch_q       <= branch_d;
      mem_to_reg_q   <= mem_to_reg_d;
      mem_write_q    <= mem_write_d;
      reg_write_q    <= reg_write_d;
      imm_to_reg_q   <= imm_to_reg_d;
      alu_op_q       <= alu_op_d;
      imm_q          <= imm_d;
      illegal_q      <= illegal_d;
      put_overflow_q <= put_overflow_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.branchFlag   = branch_q;
  assign bus.memToRegFlag = mem_to_reg_q;
  assign bus.memWriteFlag = mem_write_q;
  assign bus.regWriteFlag = reg_write_q;
  assign bus.immtoRegFlag = imm_to_reg_q;
  assign bus.ALUOp        = alu_op_q;
  assign bus.imm          = imm_q;
  assign bus.illegal      = illegal_q;
  assign bus.put_overflow = put_overflow_q;
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: directed literal scenarios, then random traffic
// checked every cycle against a chunk-queue model of the decoder.
module tb_ctrl_decode_pipe;
  localparam int IW   = 9;
  localparam int OPW  = 4;
  localparam int IMMW = 16;
  localparam int VW   = IW - 1;
  localparam int PUTS = IMMW / VW;

  localparam logic [3:0] ALU_TAB [16] = '{4'hF, 4'hF, 4'hF, 4'h5, 4'h6, 4'h1, 4'h2, 4'h0,
                                          4'hF, 4'h9, 4'h7, 4'h8, 4'h3, 4'h4, 4'hF, 4'hF};
  localparam logic [15:0] RW_MASK = 16'h30FB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ctrl_decode_pipe_if #(.IW(IW), .IMMW(IMMW)) bus ();
  ctrl_decode_pipe #(.IW(IW), .OPW(OPW), .IMMW(IMMW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, expv);
    end
  endtask

  // Model: pending put payloads as a queue, newest at the back.
  logic [VW-1:0]   chunks[$];
  logic            m_ok = 1'b0, m_rst = 1'b0, m_vld = 1'b0, m_ovf = 1'b0;
  logic [IMMW-1:0] m_imm = '0;
  logic [3:0]      m_alu = 4'hF;
  logic            m_br = 0, m_m2r = 0, m_mw = 0, m_rw = 0, m_i2r = 0, m_ill = 0;

  always @(posedge clk) begin : model
    logic [OPW-1:0]  op;
    logic            rdy;
    logic [IMMW-1:0] v;
    if (!rst_n) begin
      chunks.delete();
      m_ok = 1; m_rst = 1; m_vld = 0; m_ovf = 0;
      m_imm = '0; m_alu = 4'hF;
      m_br = 0; m_m2r = 0; m_mw = 0; m_rw = 0; m_i2r = 0; m_ill = 0;
    end else begin
      m_rst = 0;
      m_ovf = 0;
      rdy = !m_vld || bus.out_ready;
      if (m_vld && bus.out_ready) m_vld = 0;
      if (bus.in_valid && rdy) begin
        if (bus.instruction[0]) begin
          if (chunks.size() == PUTS) begin
            m_ovf = 1;
            void'(chunks.pop_front());
          end
          chunks.push_back(bus.instruction[IW-1:1]);
        end else begin
          op = bus.instruction[OPW:1];
          v = '0;
          foreach (chunks[i]) v = (v << VW) | IMMW'(chunks[i]);
          chunks.delete();
          m_imm = v;
          m_vld = 1;
          m_alu = ALU_TAB[op];
          m_rw  = RW_MASK[op];
          m_i2r = (op == 0);
          m_m2r = (op == 1);
          m_mw  = (op == 2);
          m_br  = (op == 8);
          m_ill = (op >= 14);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("out_valid", bus.out_valid, m_vld);
      chk("in_ready", bus.in_ready, rst_n && (!m_vld || bus.out_ready));
      chk("put_overflow", bus.put_overflow, m_ovf);
      if (m_vld || m_rst) begin
        chk("imm", bus.imm, m_imm);
        chk("ALUOp", bus.ALUOp, m_alu);
        chk("branchFlag", bus.branchFlag, m_br);
        chk("memToRegFlag", bus.memToRegFlag, m_m2r);
        chk("memWriteFlag", bus.memWriteFlag, m_mw);
        chk("regWriteFlag", bus.regWriteFlag, m_rw);
        chk("immtoRegFlag", bus.immtoRegFlag, m_i2r);
        chk("illegal", bus.illegal, m_ill);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Called just after a rising edge; returns just after the edge that took the word.
  task automatic send(input logic [IW-1:0] w);
    int k = 0;
    bus.in_valid    = 1'b1;
    bus.instruction = w;
    @(negedge clk);
    while (!bus.in_ready && k < 20) begin
      k++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed %0b, expected 1 within 20 cycles", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.instruction = '0;
    bus.out_ready   = 1'b1;
    rst_n           = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_ALUOp", bus.ALUOp, 4'hF);
    chk("rst_imm", bus.imm, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    step();
    rst_n = 1'b1;

    // Two puts then LI
    send(9'h025); send(9'h069); send(9'h000);
    @(negedge clk);
    chk("t1_vld", bus.out_valid, 1);
    chk("t1_i2r", bus.immtoRegFlag, 1);
    chk("t1_imm", bus.imm, 16'h1234);
    chk("t1_rw", bus.regWriteFlag, 1);
    step();

    // Third put overflows, ADD sees the two newest chunks
    send(9'h025); send(9'h069); send(9'h0AD);
    @(negedge clk);
    chk("t2_ovf", bus.put_overflow, 1);
    step();
    send(9'h006);
    @(negedge clk);
    chk("t2_alu", bus.ALUOp, 4'b0101);
    chk("t2_imm", bus.imm, 16'h3456);
    step();

    // ST held under backpressure
    bus.out_ready = 1'b0;
    send(9'h004);
    repeat (3) begin
      @(negedge clk);
      chk("t3_vld", bus.out_valid, 1);
      chk("t3_mw", bus.memWriteFlag, 1);
      chk("t3_rw", bus.regWriteFlag, 0);
      chk("t3_in_ready", bus.in_ready, 0);
    end
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t3_in_ready_rel", bus.in_ready, 1);
    step();
    @(negedge clk);
    chk("t3_drained", bus.out_valid, 0);
    step();

    // BEQ then JMP back to back
    bus.in_valid = 1'b1; bus.instruction = 9'h012;
    @(negedge clk);
    chk("t4_rdy", bus.in_ready, 1);
    step();
    bus.instruction = 9'h010;
    @(negedge clk);
    chk("t4_beq_vld", bus.out_valid, 1);
    chk("t4_beq_alu", bus.ALUOp, 4'b1001);
    chk("t4_beq_rw", bus.regWriteFlag, 0);
    chk("t4_beq_imm", bus.imm, 0);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t4_jmp_vld", bus.out_valid, 1);
    chk("t4_jmp_br", bus.branchFlag, 1);
    chk("t4_jmp_rw", bus.regWriteFlag, 0);
    chk("t4_jmp_imm", bus.imm, 0);
    step();

    // Reset discards a partial immediate
    send(9'h025);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_in_ready_rst", bus.in_ready, 0);
    step();
    @(negedge clk);
    chk("t5_vld", bus.out_valid, 0);
    chk("t5_alu", bus.ALUOp, 4'hF);
    chk("t5_imm", bus.imm, 0);
    chk("t5_rw", bus.regWriteFlag, 0);
    chk("t5_ovf", bus.put_overflow, 0);
    step();
    rst_n = 1'b1;
    send(9'h000);
    @(negedge clk);
    chk("t5_li_vld", bus.out_valid, 1);
    chk("t5_li_imm", bus.imm, 0);
    chk("t5_li_i2r", bus.immtoRegFlag, 1);
    step();

    // Undefined opcode
    send(9'h01C);
    @(negedge clk);
    chk("t6_ill", bus.illegal, 1);
    chk("t6_alu", bus.ALUOp, 4'hF);
    chk("t6_rw", bus.regWriteFlag, 0);
    step();

    repeat (3000) begin
      bus.in_valid    = ($urandom_range(0, 2) != 0);
      bus.instruction = IW'($urandom);
      bus.out_ready   = ($urandom_range(0, 3) != 0);
      rst_n           = ($urandom_range(0, 249) != 0);
      step();
    end
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
